// File: rtl/occ_pair_fetch.sv
// rtl/occ_pair_fetch.sv - Occ-table pair fetch stage: reads Occ(sym,k-1) and Occ(sym,l) for indel positions.
// Position code values are parameters so they can track the pipeline's shared code table.
module occ_pair_fetch #(
  parameter int PW          = 8,
  parameter int CW          = 8,
  parameter int AW          = 12,
  parameter int POSW        = 5,
  parameter int A_INSERTION = 11,
  parameter int C_INSERTION = 12,
  parameter int G_INSERTION = 13,
  parameter int T_INSERTION = 14,
  parameter int A_DELETION  = 15,
  parameter int C_DELETION  = 16,
  parameter int G_DELETION  = 17,
  parameter int T_DELETION  = 18
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PW-1:0]   i_in,
  input  logic [PW-1:0]   z_in,
  input  logic [PW-1:0]   k_in,
  input  logic [PW-1:0]   l_in,
  input  logic [AW-1:0]   addr_in,
  input  logic [POSW-1:0] position_in,
  output logic            rom_ce,
  output logic [PW-1:0]   rom_addr,
  input  logic [4*CW-1:0] rom_data,
  input  logic            rom_valid,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PW-1:0]   i_out,
  output logic [PW-1:0]   z_out,
  output logic [PW-1:0]   k_out,
  output logic [PW-1:0]   l_out,
  output logic [AW-1:0]   addr_out,
  output logic [POSW-1:0] position_out,
  output logic [CW-1:0]   occ_k,
  output logic [CW-1:0]   occ_l
);

  typedef enum logic [2:0] {IDLE, RD_K, WAIT_K, RD_L, WAIT_L, DONE} state_t;

  state_t     state, state_nxt;
  logic [1:0] sym;
  logic [1:0] sym_dec;
  logic       is_fetch;
  logic [CW-1:0] rom_count;

  always_comb begin
    is_fetch = 1'b1;
    sym_dec  = 2'd0;
    case (position_in)
      POSW'(A_INSERTION), POSW'(A_DELETION): sym_dec = 2'd0;
      POSW'(C_INSERTION), POSW'(C_DELETION): sym_dec = 2'd1;
      POSW'(G_INSERTION), POSW'(G_DELETION): sym_dec = 2'd2;
      POSW'(T_INSERTION), POSW'(T_DELETION): sym_dec = 2'd3;
      default:                               is_fetch = 1'b0;
    endcase
  end

  always_comb begin
    rom_count = '0;
    case (sym)
      2'd0:    rom_count = rom_data[CW-1:0];
      2'd1:    rom_count = rom_data[2*CW-1:CW];
      2'd2:    rom_count = rom_data[3*CW-1:2*CW];
      default: rom_count = rom_data[4*CW-1:3*CW];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sym          <= 2'd0;
      i_out        <= '0;
      z_out        <= '0;
      k_out        <= '0;
      l_out        <= '0;
      addr_out     <= '0;
      position_out <= '0;
      occ_k        <= '0;
      occ_l        <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            i_out        <= i_in;
            z_out        <= z_in;
            k_out        <= k_in;
            l_out        <= l_in;
            addr_out     <= addr_in;
            position_out <= position_in;
            sym          <= sym_dec;
            occ_k        <= '0;
            occ_l        <= '0;
          end
        end
        WAIT_K: if (rom_valid) occ_k <= rom_count;
        WAIT_L: if (rom_valid) occ_l <= rom_count;
        default: ;
      endcase
    end
  end

  // Control outputs depend only on the state register and captured tuple.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rom_ce    = 1'b0;
    rom_addr  = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (!is_fetch)        state_nxt = DONE;
          else if (k_in == '0)  state_nxt = RD_L;
          else                  state_nxt = RD_K;
        end
      end
      RD_K: begin
        rom_ce    = 1'b1;
        rom_addr  = k_out - PW'(1);
        state_nxt = WAIT_K;
      end
      WAIT_K: if (rom_valid) state_nxt = RD_L;
      RD_L: begin
        rom_ce    = 1'b1;
        rom_addr  = l_out;
        state_nxt = WAIT_L;
      end
      WAIT_L: if (rom_valid) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/occ_pair_fetch.md
# occ_pair_fetch

Parametrised Occ-table fetch stage for the backtracking search pipeline. It sits between the parameter stage and the SA-interval update stage. For insertion/deletion positions it reads the Occ ROM twice, at address k-1 and at address l, and extracts the count for the symbol selected by `position`. It forwards both counts together with the search tuple (i, z, k, l, addr, position) through valid/ready handshakes. Unlike the previous single-read stage, it is registered and FSM-driven, handles k=0 without a ROM access, and is width-parametrised.

## Interface
Parameters:
- `PW`, 8: width of i/z/k/l and of the Occ ROM address.
- `CW`, 8: width of one Occ count. The ROM word is 4*CW wide, packed A=[CW-1:0], C, G, T=[4CW-1:3CW].
- `AW`, 12: width of the parameter-memory address tag `addr`.
- `POSW`, 5: width of the `position` code. Code values come from `config.v`.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input tuple valid.
- `in_ready` out 1: block can accept a tuple.
- `i_in`, `z_in`, `k_in`, `l_in` in PW each: search parameters.
- `addr_in` in AW: parameter address tag.
- `position_in` in POSW: execution position code.
- `rom_ce` out 1: Occ ROM read strobe.
- `rom_addr` out PW: Occ ROM address.
- `rom_data` in 4*CW: Occ ROM word.
- `rom_valid` in 1: `rom_data` valid (one-cycle pulse per read).
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `i_out`, `z_out`, `k_out`, `l_out` out PW: registered copies of the inputs.
- `addr_out` out AW, `position_out` out POSW: registered tags.
- `occ_k` out CW: Occ(sym, k-1).
- `occ_l` out CW: Occ(sym, l).

## Operation
- FSM states: IDLE, RD_K, WAIT_K, RD_L, WAIT_L, DONE. Reset state is IDLE.
- IDLE:
  - `in_ready`=1. On `in_valid`, capture all inputs and decode the symbol: A/C/G/T_INSERTION or _DELETION select sym 0/1/2/3.
  - Fetch position with k≠0: go to RD_K.
  - Fetch position with k=0: set occ_k=0 and go to RD_L. No read at address -1 is issued.
  - Any other code (NONE, STOP_1/2, *_MATCH, *_SNP, undefined): set occ_k=occ_l=0 and go to DONE. No ROM access.
- RD_K: `rom_ce`=1 and `rom_addr`=k-1 (mod 2^PW) for exactly one cycle. Go to WAIT_K.
- WAIT_K: hold until `rom_valid`. Then occ_k ← `rom_data` slice [sym*CW +: CW] and go to RD_L.
- RD_L: `rom_ce`=1 and `rom_addr`=l for one cycle. Go to WAIT_L.
- WAIT_L: on `rom_valid`, occ_l ← slice and go to DONE.
- DONE: `out_valid`=1 and all outputs held stable. On `out_ready`, go to IDLE.
- `in_ready` is 1 only in IDLE. At most one tuple is in flight.
- `rom_valid` is ignored outside WAIT_K/WAIT_L.
- `rom_ce` is 0 in every state except RD_K and RD_L. `rom_addr` is 0 when `rom_ce`=0.

## Timing
- Reset value of every output is 0, except `in_ready`, which is 1 (IDLE). Occ registers and the captured tuple are cleared.
- Reset asserted mid-operation: the FSM is in IDLE at the next edge and any pending ROM response is discarded. A `rom_valid` arriving after reset is ignored.
- With a 1-cycle ROM (`rom_valid` in the cycle after `rom_ce`), counted from the accept edge (cycle 0):
  - `out_valid` rises at cycle 5 for the normal case.
  - At cycle 3 for k=0.
  - At cycle 1 for a non-fetch position.
- Added ROM latency extends the corresponding WAIT state cycle for cycle.
- Output back-pressure: DONE holds indefinitely. Outputs must not change while `out_valid`=1 and `out_ready`=0.
- Outputs are registered; `rom_ce` and `rom_addr` are decoded from the state register, with no input-to-output combinational path.

## Test plan
- Reset: hold `rst`=1 for 2 cycles -> all outputs 0, `in_ready`=1, `rom_ce`=0.
- C_INSERTION, k=5, l=9, ROM word at address 4 = 0x04_03_02_01, at address 9 = 0x40_30_20_10, 1-cycle ROM:
  - `rom_ce` at cycles 1 and 3 with `rom_addr` 4 then 9.
  - `out_valid` at cycle 5 with `occ_k`=0x02 and `occ_l`=0x20.
  - The tuple is echoed on the outputs.
- T_DELETION with k=0, l=3:
  - Exactly one ROM read, at address 3.
  - `occ_k`=0, `occ_l` = bits [31:24] of word 3.
  - `out_valid` at cycle 3.
- A_MATCH -> no `rom_ce`, `occ_k`=`occ_l`=0, `out_valid` at cycle 1.
- ROM latency 3 cycles and `out_ready` held low for 4 cycles:
  - Correct counts are captured.
  - Outputs stay stable while stalled.
  - `in_ready` returns to 1 only in the cycle after `out_ready`.
- Reset pulsed in WAIT_L, with a stray `rom_valid` afterwards -> IDLE, outputs 0, stray response ignored. The next tuple then completes correctly.
